bmc_soft_pipe: RTL and testbench
================================

// Module: bmc_soft_pipe
// PURPOSE
//  Parametrised branch-metric unit for rate-1/N Viterbi decoding.
//  - Computes the distance from one received symbol (N samples, Q soft bits each) to all 2^N expected codewords.
//  - Two-stage registered pipeline with valid/ready handshakes on both sides.
//  - Sits between the demapper/depuncturer and the ACS array; metric bus feeds ACS butterflies directly.
//  - Q=1, N=2 reproduces the fixed hard-decision 2-bit Hamming BMC, plus pipelining and flow control.
// PARAMETERS
//  N      2   code outputs per trellis step (1..4); 2^N metrics produced
//  Q      3   soft bits per sample (1..4); 0 = strong '0', 2^Q-1 = strong '1'
//  CNT_W  16  width of per-frame symbol counter
//  localparam SMAX = 2^Q-1; MW = clog2(N*SMAX+1) metric width (N=2,Q=3 -> MW=4)
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          synchronous, active-high reset
//  in_valid   in   1          input symbol valid
//  in_ready   out  1          block accepts symbol this cycle
//  in_sample  in   N*Q        sample i at [i*Q +: Q]; i=0 pairs with codeword bit 0
//  in_last    in   1          last symbol of frame
//  out_valid  out  1          metric bus valid
//  out_ready  in   1          downstream (ACS) accepts
//  out_metric out  (2^N)*MW   metric for codeword c at [c*MW +: MW]
//  out_last   out  1          in_last delayed with its symbol
//  out_cnt    out  CNT_W      0-based index of current output symbol within its frame
// BEHAVIOUR
//  - Reset: out_valid=0, out_metric=0, out_last=0, out_cnt=0, both stage valids=0; in_ready=0 while rst=1.
//  - Distance per sample: d0(s)=s (expected '0'), d1(s)=SMAX-s (expected '1'); unsigned, no overflow.
//  - Metric: M[c] = sum over i of (c[i] ? d1(s_i) : d0(s_i)), width MW, exact (never saturates).
//  - Stage 1 registers per-sample d0/d1 + last. Stage 2 registers all 2^N sums + last.
//  - Latency: accept on cycle t -> out_valid on t+2 when unstalled. Throughput: 1 symbol/cycle.
//  - Flow control:
//    - Stage k advances when its successor is empty or being drained the same cycle.
//    - in_ready = !s1_valid | s2_advance (combinational, no skid buffer).
//    - out_* held stable while out_valid & !out_ready.
//    - Back-to-back stall/release loses and duplicates nothing.
//  - out_cnt:
//    - Increments on each output handshake (out_valid & out_ready).
//    - Clears to 0 on the handshake of a symbol with out_last=1, so the next frame starts at 0.
//    - Wraps modulo 2^CNT_W with no flag.
//  - Simultaneous input accept and output drain with full pipe: all stages shift, no bubble.
//  - rst mid-frame: pipeline contents discarded, counter cleared; first post-reset symbol is index 0.
//  - in_sample/in_last sampled only when in_valid & in_ready; ignored otherwise.
// CONFIGURATION
//  - BMC_SOFT_PIPE_ERASURE_EN defined:
//    - Adds port in_erase (in, N): bit i=1 marks sample i punctured/erased.
//    - Erased sample contributes 0 to every metric (both d0 and d1 forced 0).
//    - Mask travels through stage 1 with its symbol.
//  - Undefined: no in_erase port; all samples always contribute.
// TESTING
//  - N=2,Q=1 hard: samples (1,1) -> M[0]=2,M[1]=1,M[2]=1,M[3]=0; (0,1) -> M={1,2,0,1}; out_valid at t+2.
//  - N=2,Q=3: s0=5,s1=2 -> d0={5,2}, d1={2,5}; M[0]=7,M[1]=4,M[2]=10,M[3]=7.
//  - Stream 8 symbols, out_ready low cycles 3-6: in_ready drops once pipe is full; all 8 exit in order, held stable while stalled.
//  - Frame of 5 (last on 5th) then frame of 3: out_cnt 0..4, then 0..2; out_last aligned with indices 4 and 2.
//  - rst asserted with 2 symbols in flight: next cycle out_valid=0, out_cnt=0; no stale symbol emerges.
//  - ERASURE_EN, Q=3: s0=7 erased, s1=0 -> M[0]=0,M[1]=0,M[2]=7,M[3]=7; without macro -> {7,0,14,7}.

Source files
------------

// File: rtl/bmc_soft_pipe.sv
// Branch-metric unit for rate-1/N Viterbi: 2^N soft distances, two-stage valid/ready pipe, 2-cycle latency,
// full throughput, no skid buffer. Define BMC_SOFT_PIPE_ERASURE_EN to add the in_erase puncture mask port.
module bmc_soft_pipe #(
   parameter int N     = 2,
   parameter int Q     = 3,
   parameter int CNT_W = 16,
   localparam int SMAX = (1 << Q) - 1,
   localparam int MW   = $clog2(N * SMAX + 1),
   localparam int NC   = 1 << N
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N*Q-1:0]     in_sample,
   input  logic               in_last,
`ifdef BMC_SOFT_PIPE_ERASURE_EN
   input  logic [N-1:0]       in_erase,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NC*MW-1:0]   out_metric,
   output logic               out_last,
   output logic [CNT_W-1:0]   out_cnt
);

   logic           s1_valid;
   logic           s1_last;
   logic [Q-1:0]   s1_d0 [N];
   logic [Q-1:0]   s1_d1 [N];
   logic [N-1:0]   s1_mask;
   logic           s1_load;
   logic           s2_advance;
   logic [MW-1:0]  sum [NC];

   assign s2_advance = !out_valid || out_ready;
   assign s1_load    = !s1_valid || s2_advance;
   assign in_ready   = !rst && s1_load;

`ifdef BMC_SOFT_PIPE_ERASURE_EN
   logic [N-1:0] s1_erase;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_erase <= '0;
      end else if (s1_load && in_valid) begin
         s1_erase <= in_erase;
      end
   end

   assign s1_mask = s1_erase;
`else
   assign s1_mask = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         for (int i = 0; i < N; i++) begin
            s1_d0[i] <= '0;
            s1_d1[i] <= '0;
         end
      end else if (s1_load) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_last <= in_last;
            for (int i = 0; i < N; i++) begin
               s1_d0[i] <= in_sample[i*Q +: Q];
               s1_d1[i] <= Q'(SMAX) - in_sample[i*Q +: Q];
            end
         end
      end
   end

   // MW is sized for N*SMAX, so the running sum can never wrap.
   always_comb begin
      for (int c = 0; c < NC; c++) begin
         sum[c] = '0;
         for (int i = 0; i < N; i++) begin
            if (!s1_mask[i]) begin
               sum[c] = sum[c] + ((((c >> i) & 1) != 0) ? MW'(s1_d1[i]) : MW'(s1_d0[i]));
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_metric <= '0;
         out_last   <= 1'b0;
         out_cnt    <= '0;
      end else begin
         if (out_valid && out_ready) begin
            out_cnt <= out_last ? '0 : out_cnt + 1'b1;
         end
         if (s2_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_last <= s1_last;
               for (int c = 0; c < NC; c++) begin
                  out_metric[c*MW +: MW] <= sum[c];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Randomised bench for bmc_soft_pipe (N=2,Q=3 main instance plus a Q=1 hard-decision instance).
module tb_bmc_soft_pipe;
   localparam int N  = 2;
   localparam int Q  = 3;
   localparam int MW = 4;
   localparam int CW = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [N*Q-1:0]  in_sample = '0;
   logic            in_last = 1'b0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [4*MW-1:0] out_metric;
   logic            out_last;
   logic [CW-1:0]   out_cnt;
   logic [1:0]      erase_drv = 2'b00;
   logic [1:0]      eff_erase;

   logic            h_valid = 1'b0;
   logic            h_ready;
   logic [1:0]      h_sample = 2'b00;
   logic            h_last = 1'b0;
   logic            h_ovalid;
   logic            h_oready = 1'b1;
   logic [7:0]      h_metric;
   logic            h_olast;
   logic [CW-1:0]   h_cnt;

`ifdef BMC_SOFT_PIPE_ERASURE_EN
   logic [1:0] in_erase;
   logic [1:0] h_erase;
   assign in_erase  = erase_drv;
   assign h_erase   = 2'b00;
   assign eff_erase = erase_drv;
   localparam logic [15:0] ERASE_EXP = 16'h7700;
`else
   assign eff_erase = 2'b00;
   localparam logic [15:0] ERASE_EXP = 16'h7E07;
`endif

   bmc_soft_pipe #(.N(N), .Q(Q), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_sample(in_sample), .in_last(in_last),
`ifdef BMC_SOFT_PIPE_ERASURE_EN
      .in_erase(in_erase),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_metric(out_metric),
      .out_last(out_last), .out_cnt(out_cnt)
   );

   bmc_soft_pipe #(.N(2), .Q(1), .CNT_W(CW)) dut_hard (
      .clk(clk), .rst(rst), .in_valid(h_valid), .in_ready(h_ready),
      .in_sample(h_sample), .in_last(h_last),
`ifdef BMC_SOFT_PIPE_ERASURE_EN
      .in_erase(h_erase),
`endif
      .out_valid(h_ovalid), .out_ready(h_oready), .out_metric(h_metric),
      .out_last(h_olast), .out_cnt(h_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0]   m;
      logic          last;
      logic [CW-1:0] cnt;
   } rec_t;

   rec_t exp_q[$];
   rec_t obs_q[$];
   int   mdl_pos = 0;
   int   checks = 0;
   int   errors = 0;

   // Distance to codeword c: sum over samples of s (bit 0) or 7-s (bit 1); erased samples count 0.
   function automatic logic [15:0] model(input logic [5:0] smp, input logic [1:0] er);
      logic [15:0] r;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         int acc;
         acc = 0;
         for (int i = 0; i < 2; i++) begin
            int s;
            s = int'(smp[i*3 +: 3]);
            if (!er[i]) acc += ((c >> i) & 1) ? (7 - s) : s;
         end
         r[c*4 +: 4] = 4'(acc);
      end
      return r;
   endfunction

   // Called right after inputs are set at a negedge; records the handshakes of the coming edge.
   task automatic step();
      rec_t r;
      #1;
      if (!rst && in_valid && in_ready) begin
         r.m    = model(in_sample, eff_erase);
         r.last = in_last;
         r.cnt  = CW'(mdl_pos);
         exp_q.push_back(r);
         mdl_pos = in_last ? 0 : (mdl_pos + 1) % 65536;
      end
      if (!rst && out_valid && out_ready) begin
         r.m    = out_metric;
         r.last = out_last;
         r.cnt  = out_cnt;
         obs_q.push_back(r);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      step();
      step();
      checks += 5;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      if (out_metric !== '0) begin errors++; $display("FAIL reset_out_metric got %h want 0", out_metric); end
      if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
      if (out_cnt !== '0) begin errors++; $display("FAIL reset_out_cnt got %0d want 0", out_cnt); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      rst = 1'b0;
      in_valid = 1'b0;
      step();
      exp_q.delete();
      obs_q.delete();
      mdl_pos = 0;
   endtask

   task automatic test_known();
      in_valid = 1'b1; in_sample = {3'd2, 3'd5}; in_last = 1'b0; erase_drv = 2'b00;
      step();
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_t1 out_valid got %b want 0", out_valid); end
      step();
      checks += 2;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_t2 out_valid got %b want 1", out_valid); end
      if (out_metric !== 16'h7A47) begin errors++; $display("FAIL soft_5_2 metric got %h want 7a47", out_metric); end
      in_valid = 1'b1; in_sample = {3'd0, 3'd7}; in_last = 1'b1; erase_drv = 2'b01;
      step();
      in_valid = 1'b0; erase_drv = 2'b00; in_last = 1'b0;
      step();
      checks += 3;
      if (out_metric !== ERASE_EXP) begin errors++; $display("FAIL erase_7_0 metric got %h want %h", out_metric, ERASE_EXP); end
      if (out_last !== 1'b1) begin errors++; $display("FAIL erase_7_0 last got %b want 1", out_last); end
      if (out_cnt !== 16'd1) begin errors++; $display("FAIL erase_7_0 cnt got %0d want 1", out_cnt); end
      step();
      checks++;
      if (out_cnt !== 16'd0) begin errors++; $display("FAIL frame_end_cnt got %0d want 0", out_cnt); end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_hard();
      h_valid = 1'b1; h_sample = 2'b11;
      #1;
      checks++;
      if (h_ready !== 1'b1) begin errors++; $display("FAIL hard_ready got %b want 1", h_ready); end
      @(negedge clk);
      h_sample = 2'b10;
      @(negedge clk);
      h_valid = 1'b0;
      #1;
      checks += 2;
      if (h_ovalid !== 1'b1) begin errors++; $display("FAIL hard_11_valid got %b want 1", h_ovalid); end
      if (h_metric !== 8'h16) begin errors++; $display("FAIL hard_11_metric got %h want 16", h_metric); end
      @(negedge clk);
      #1;
      checks++;
      if (h_metric !== 8'h49) begin errors++; $display("FAIL hard_01_metric got %h want 49", h_metric); end
      @(negedge clk);
   endtask

   task automatic test_stall();
      int   sent = 0;
      bit   saw_drop = 0;
      bit   hold = 0;
      rec_t prev;
      for (int cyc = 0; cyc < 60 && !(sent == 8 && obs_q.size() == 8); cyc++) begin
         out_ready = !(cyc >= 3 && cyc <= 6);
         in_valid  = (sent < 8);
         in_sample = 6'($urandom);
         in_last   = (sent == 7);
         #1;
         if (hold) begin
            checks++;
            if (out_valid !== 1'b1 || out_metric !== prev.m || out_last !== prev.last || out_cnt !== prev.cnt) begin
               errors++;
               $display("FAIL stall_hold cyc %0d got v=%b m=%h l=%b c=%0d want v=1 m=%h l=%b c=%0d",
                        cyc, out_valid, out_metric, out_last, out_cnt, prev.m, prev.last, prev.cnt);
            end
         end
         if (in_valid && !in_ready) saw_drop = 1;
         if (in_valid && in_ready) sent++;
         hold = out_valid && !out_ready;
         prev.m = out_metric; prev.last = out_last; prev.cnt = out_cnt;
         step();
      end
      in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      checks += 2;
      if (!saw_drop) begin errors++; $display("FAIL stall_in_ready_drop got 0 want 1"); end
      if (obs_q.size() != 8 || exp_q.size() != 8) begin
         errors++; $display("FAIL stall_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         rec_t o = obs_q.pop_front();
         rec_t e = exp_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL stall_seq got m=%h l=%b c=%0d want m=%h l=%b c=%0d", o.m, o.last, o.cnt, e.m, e.last, e.cnt);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_frames();
      int sent = 0;
      int idx = 0;
      int exp_cnt[8] = '{0, 1, 2, 3, 4, 0, 1, 2};
      for (int cyc = 0; cyc < 300 && !(sent == 8 && obs_q.size() == 8); cyc++) begin
         in_valid  = (sent < 8) && ($urandom_range(0, 1) == 1);
         out_ready = ($urandom_range(0, 9) < 7);
         in_sample = 6'($urandom);
         in_last   = (sent == 4) || (sent == 7);
         #1;
         if (in_valid && in_ready) sent++;
         step();
      end
      in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      checks++;
      if (obs_q.size() != 8 || exp_q.size() != 8) begin
         errors++; $display("FAIL frames_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         rec_t o = obs_q.pop_front();
         rec_t e = exp_q.pop_front();
         checks += 2;
         if (o !== e) begin
            errors++;
            $display("FAIL frames_seq got m=%h l=%b c=%0d want m=%h l=%b c=%0d", o.m, o.last, o.cnt, e.m, e.last, e.cnt);
         end
         if (idx < 8 && (int'(o.cnt) != exp_cnt[idx] || o.last !== (idx == 4 || idx == 7))) begin
            errors++;
            $display("FAIL frames_index %0d got c=%0d l=%b want c=%0d l=%b", idx, o.cnt, o.last, exp_cnt[idx], (idx == 4 || idx == 7));
         end
         idx++;
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_random();
      int sent = 0;
      int total = 0;
      for (int cyc = 0; cyc < 2000 && !(sent == 150 && obs_q.size() == exp_q.size()); cyc++) begin
         in_valid  = (sent < 150) && ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         in_sample = 6'($urandom);
         erase_drv = 2'($urandom);
         in_last   = ($urandom_range(0, 7) == 0);
         #1;
         if (in_valid && in_ready) sent++;
         step();
      end
      in_valid = 1'b0; in_last = 1'b0; erase_drv = 2'b00; out_ready = 1'b1;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         rec_t o = obs_q.pop_front();
         rec_t e = exp_q.pop_front();
         total++;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL random_seq got m=%h l=%b c=%0d want m=%h l=%b c=%0d", o.m, o.last, o.cnt, e.m, e.last, e.cnt);
         end
      end
      checks++;
      if (total != 150 || exp_q.size() != 0 || obs_q.size() != 0) begin
         errors++; $display("FAIL random_count got %0d want 150", total);
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_rst_mid();
      in_last = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_sample = 6'($urandom);
         if (k >= 3) out_ready = 1'b0;
         step();
      end
      checks++;
      if (out_cnt === '0) begin errors++; $display("FAIL rst_mid_precond cnt got 0 want nonzero"); end
      rst = 1'b1; in_valid = 1'b0;
      step();
      checks += 2;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
      if (out_cnt !== '0) begin errors++; $display("FAIL rst_mid_cnt got %0d want 0", out_cnt); end
      rst = 1'b0;
      exp_q.delete(); obs_q.delete(); mdl_pos = 0;
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) step();
      checks++;
      if (obs_q.size() != 0) begin errors++; $display("FAIL rst_mid_stale got %0d want 0", obs_q.size()); end
      in_valid = 1'b1; in_sample = {3'd6, 3'd1}; in_last = 1'b1;
      step();
      in_valid = 1'b0; in_last = 1'b0;
      for (int k = 0; k < 10 && obs_q.size() == 0; k++) step();
      checks++;
      if (obs_q.size() != 1 || exp_q.size() != 1) begin
         errors++; $display("FAIL rst_mid_first got %0d want 1", obs_q.size());
      end else begin
         rec_t o = obs_q.pop_front();
         rec_t e = exp_q.pop_front();
         checks++;
         if (o !== e || o.cnt !== '0) begin
            errors++;
            $display("FAIL rst_mid_seq got m=%h c=%0d want m=%h c=0", o.m, o.cnt, e.m);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_known();
      test_hard();
      test_stall();
      test_frames();
      test_random();
      test_rst_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
